// File: rtl/ram_pkg.sv
// Shared constants and byte-lane helpers for the byte-enable block RAM family.
// Used by ram_sdp_be and ram_rdw_bypass.
package ram_pkg;

  localparam int BYTE_W = 8;

  // Number of byte lanes in a data word.
  function automatic int nbytes(input int width);
    return width / BYTE_W;
  endfunction

  // Byte-enable width, never below one bit so port ranges stay legal.
  function automatic int be_w(input int width);
    return (nbytes(width) > 0) ? nbytes(width) : 1;
  endfunction

  function automatic bit width_ok(input int width);
    return (width > 0) && ((width % BYTE_W) == 0);
  endfunction

endpackage

// File: rtl/ram_rdw_bypass.sv
// Write-first collision merge: captures the collision flag, byte enables and write data
// alongside the array read, then overlays the written lanes onto the old word.
module ram_rdw_bypass
  import ram_pkg::*;
#(
  parameter int Width = 32,
  localparam int BeW = be_w(Width)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             collide,
  input  logic [BeW-1:0]   wrbe,
  input  logic [Width-1:0] wrdata,
  input  logic [Width-1:0] raw,
  output logic [Width-1:0] merged
);

  logic             hit_q;
  logic [BeW-1:0]   be_q;
  logic [Width-1:0] wd_q;

  // Only updated when a read is accepted, so the merged word holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q <= 1'b0;
      be_q  <= '0;
      wd_q  <= '0;
    end else if (en) begin
      hit_q <= collide;
      be_q  <= wrbe;
      wd_q  <= wrdata;
    end
  end

  always_comb begin
    merged = raw;
    if (hit_q) begin
      for (int i = 0; i < BeW; i++) begin
        if (be_q[i]) merged[i*BYTE_W +: BYTE_W] = wd_q[i*BYTE_W +: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/ram_sdp_be.sv
// Simple-dual-port block RAM with byte-lane writes, registered read and read-valid strobe.
// Compile-time option RAMGEN_BYPASS_EN: write-first per lane on same-address collisions.
module ram_sdp_be
  import ram_pkg::*;
#(
  parameter int Width   = 32,
  parameter int Depth   = 10,
  parameter int OUT_REG = 0,
  localparam int BeW = be_w(Width)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wren,
  input  logic [BeW-1:0]   wrbe,
  input  logic [Depth-1:0] wraddr,
  input  logic [Width-1:0] wrdata,
  input  logic             rden,
  input  logic [Depth-1:0] rdaddr,
  output logic             rdvalid,
  output logic [Width-1:0] rddata
);

  localparam int Words = 2 ** Depth;

  if (!width_ok(Width)) begin : g_width_chk
    $error("ram_sdp_be: Width must be a positive multiple of 8");
  end

`ifdef RAMGEN_BYPASS_EN
  logic [Width-1:0] mem [Words];
`else
  (* ram_style = "block" *) logic [Width-1:0] mem [Words];
`endif

  logic             do_write;
  logic             accept;
  logic             acc_q;
  logic [Width-1:0] rd_raw;
  logic [Width-1:0] rd_word;
  logic             v_b;
  logic [Width-1:0] d_b;

  // Read handshake: no back-pressure. A read with rden=1 is accepted at every edge where
  // rst=0; its word appears with a one-cycle rdvalid pulse one edge later (two with OUT_REG).
  assign do_write = wren & ~rst;
  assign accept   = rden & ~rst;

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < BeW; i++) begin
        if (wrbe[i]) mem[wraddr][i*BYTE_W +: BYTE_W] <= wrdata[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Array read register: read-before-write, so a collision always sees the old word here.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= 1'b0;
      rd_raw <= '0;
    end else begin
      acc_q <= rden;
      if (rden) rd_raw <= mem[rdaddr];
    end
  end

`ifdef RAMGEN_BYPASS_EN
  logic collide;
  assign collide = wren & (wraddr == rdaddr);

  ram_rdw_bypass #(
    .Width (Width)
  ) u_bypass (
    .clk     (clk),
    .rst     (rst),
    .en      (accept),
    .collide (collide),
    .wrbe    (wrbe),
    .wrdata  (wrdata),
    .raw     (rd_raw),
    .merged  (rd_word)
  );
`else
  assign rd_word = rd_raw;
`endif

  // Presentation stage: data only moves when a read completes, otherwise it holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_b <= 1'b0;
      d_b <= '0;
    end else begin
      v_b <= acc_q;
      if (acc_q) d_b <= rd_word;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic             v_c;
    logic [Width-1:0] d_c;

    always_ff @(posedge clk) begin
      if (rst) begin
        v_c <= 1'b0;
        d_c <= '0;
      end else begin
        v_c <= v_b;
        if (v_b) d_c <= d_b;
      end
    end

    assign rdvalid = v_c;
    assign rddata  = d_c;
  end else begin : g_no_out_reg
    assign rdvalid = v_b;
    assign rddata  = d_b;
  end

endmodule

// File: tb/tb_ram_sdp_be.sv
// Bench for ram_sdp_be: one instance with OUT_REG=0 and one with OUT_REG=1 share stimulus;
// a word-array model with per-read due-cycle queues predicts rdvalid/rddata of both.
module tb_ram_sdp_be;

  localparam int W     = 32;
  localparam int D     = 10;
  localparam int BE    = 4;
  localparam int WORDS = 1024;

  logic          clk = 1'b0;
  logic          rst, wren, rden;
  logic [BE-1:0] wrbe;
  logic [D-1:0]  wraddr, rdaddr;
  logic [W-1:0]  wrdata;
  logic          rdvalid0, rdvalid1;
  logic [W-1:0]  rddata0, rddata1;

  always #5 clk = ~clk;

  ram_sdp_be #(.Width(W), .Depth(D), .OUT_REG(0)) dut0 (
    .clk(clk), .rst(rst), .wren(wren), .wrbe(wrbe), .wraddr(wraddr), .wrdata(wrdata),
    .rden(rden), .rdaddr(rdaddr), .rdvalid(rdvalid0), .rddata(rddata0)
  );

  ram_sdp_be #(.Width(W), .Depth(D), .OUT_REG(1)) dut1 (
    .clk(clk), .rst(rst), .wren(wren), .wrbe(wrbe), .wraddr(wraddr), .wrdata(wrdata),
    .rden(rden), .rdaddr(rdaddr), .rdvalid(rdvalid1), .rddata(rddata1)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [W-1:0] mem_m [WORDS];
  logic [W-1:0] exp_q0[$], exp_q1[$];
  int           due_q0[$], due_q1[$];
  logic         exp_v0 = 1'b0, exp_v1 = 1'b0;
  logic [W-1:0] exp_d0 = '0, exp_d1 = '0;

`ifdef RAMGEN_BYPASS_EN
  localparam logic [W-1:0] COLL_EXP = 32'h0000BEEF;
`else
  localparam logic [W-1:0] COLL_EXP = 32'h00000000;
`endif

  // One clock: apply inputs, update the model, step past the edge, derive expected outputs.
  task automatic drive(input logic r, input logic we, input logic [BE-1:0] be,
                       input logic [D-1:0] wa, input logic [W-1:0] wd,
                       input logic re, input logic [D-1:0] ra);
    logic [W-1:0] v;
    rst = r; wren = we; wrbe = be; wraddr = wa; wrdata = wd; rden = re; rdaddr = ra;
    if (!r && re) begin
      v = mem_m[ra];
`ifdef RAMGEN_BYPASS_EN
      if (we && wa == ra)
        for (int i = 0; i < BE; i++) if (be[i]) v[i*8 +: 8] = wd[i*8 +: 8];
`endif
      exp_q0.push_back(v); due_q0.push_back(cyc + 1);
      exp_q1.push_back(v); due_q1.push_back(cyc + 2);
    end
    if (!r && we)
      for (int i = 0; i < BE; i++) if (be[i]) mem_m[wa][i*8 +: 8] = wd[i*8 +: 8];
    @(posedge clk);
    #1;
    if (r) begin
      exp_q0.delete(); due_q0.delete(); exp_q1.delete(); due_q1.delete();
      exp_v0 = 1'b0; exp_v1 = 1'b0; exp_d0 = '0; exp_d1 = '0;
    end else begin
      exp_v0 = 1'b0;
      if (due_q0.size() > 0 && due_q0[0] == cyc) begin
        exp_v0 = 1'b1; exp_d0 = exp_q0.pop_front(); void'(due_q0.pop_front());
      end
      exp_v1 = 1'b0;
      if (due_q1.size() > 0 && due_q1[0] == cyc) begin
        exp_v1 = 1'b1; exp_d1 = exp_q1.pop_front(); void'(due_q1.pop_front());
      end
    end
    cyc++;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
      total++;
      if (rdvalid0 !== 1'b0 || rdvalid1 !== 1'b0) begin
        bad++; $display("FAIL reset_valid got %0b/%0b exp 0/0", rdvalid0, rdvalid1);
      end
      total++;
      if (rddata0 !== '0 || rddata1 !== '0) begin
        bad++; $display("FAIL reset_data got %h/%h exp 0/0", rddata0, rddata1);
      end
    end
  endtask

  task automatic test_full_write_read();
    int n_valid = 0;
    int next_a  = 0;
    for (int a = 0; a < WORDS; a++) drive(1'b0, 1'b1, 4'hF, D'(a), 32'hA5A50000 + a, 1'b0, '0);
    for (int a = 0; a < WORDS + 3; a++) begin
      if (a < WORDS) drive(1'b0, 1'b0, '0, '0, '0, 1'b1, D'(a));
      else idle();
      total++;
      if (rdvalid0 !== exp_v0) begin
        bad++; $display("FAIL full_valid0 @%0d got %0b exp %0b", a, rdvalid0, exp_v0);
      end
      total++;
      if (rddata0 !== exp_d0) begin
        bad++; $display("FAIL full_data0 @%0d got %h exp %h", a, rddata0, exp_d0);
      end
      total++;
      if (rdvalid1 !== exp_v1 || rddata1 !== exp_d1) begin
        bad++; $display("FAIL full_out1 @%0d got %0b/%h exp %0b/%h", a, rdvalid1, rddata1, exp_v1, exp_d1);
      end
      if (rdvalid0 === 1'b1) begin
        total++;
        if (rddata0 !== 32'hA5A50000 + next_a) begin
          bad++; $display("FAIL full_pattern @%0d got %h exp %h", next_a, rddata0, 32'hA5A50000 + next_a);
        end
        next_a++;
        n_valid++;
      end
    end
    total++;
    if (n_valid != WORDS) begin
      bad++; $display("FAIL full_count got %0d exp %0d", n_valid, WORDS);
    end
  endtask

  task automatic test_byte_lanes();
    drive(1'b0, 1'b1, 4'hF, 10'd5, 32'h11223344, 1'b0, '0);
    drive(1'b0, 1'b1, 4'b0101, 10'd5, 32'hAABBCCDD, 1'b0, '0);
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 10'd5);
    idle();
    total++;
    if (rdvalid0 !== 1'b1 || rddata0 !== 32'h11BB33DD) begin
      bad++; $display("FAIL lanes0 got %0b/%h exp 1/11bb33dd", rdvalid0, rddata0);
    end
    idle();
    total++;
    if (rdvalid1 !== 1'b1 || rddata1 !== 32'h11BB33DD) begin
      bad++; $display("FAIL lanes1 got %0b/%h exp 1/11bb33dd", rdvalid1, rddata1);
    end
  endtask

  task automatic test_collision();
    drive(1'b0, 1'b1, 4'hF, 10'd7, 32'h0, 1'b0, '0);
    drive(1'b0, 1'b1, 4'b0011, 10'd7, 32'hDEADBEEF, 1'b1, 10'd7);
    idle();
    total++;
    if (rdvalid0 !== 1'b1 || rddata0 !== COLL_EXP) begin
      bad++; $display("FAIL collide0 got %0b/%h exp 1/%h", rdvalid0, rddata0, COLL_EXP);
    end
    idle();
    total++;
    if (rdvalid1 !== 1'b1 || rddata1 !== COLL_EXP) begin
      bad++; $display("FAIL collide1 got %0b/%h exp 1/%h", rdvalid1, rddata1, COLL_EXP);
    end
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 10'd7);
    idle();
    total++;
    if (rdvalid0 !== 1'b1 || rddata0 !== 32'h0000BEEF) begin
      bad++; $display("FAIL collide_after got %0b/%h exp 1/0000beef", rdvalid0, rddata0);
    end
    idle();
  endtask

  task automatic test_out_reg_latency();
    logic         ev1, ev0;
    logic [W-1:0] ed1;
    for (int j = 0; j < 8; j++) begin
      if (j < 4) drive(1'b0, 1'b0, '0, '0, '0, 1'b1, D'(j));
      else idle();
      ev1 = (j >= 2 && j <= 5);
      ev0 = (j >= 1 && j <= 4);
      ed1 = 32'hA5A50000 + ((j >= 5) ? 3 : (j - 2));
      total++;
      if (rdvalid1 !== ev1) begin
        bad++; $display("FAIL lat2_valid j=%0d got %0b exp %0b", j, rdvalid1, ev1);
      end
      total++;
      if (rdvalid0 !== ev0) begin
        bad++; $display("FAIL lat1_valid j=%0d got %0b exp %0b", j, rdvalid0, ev0);
      end
      if (j >= 2) begin
        total++;
        if (rddata1 !== ed1) begin
          bad++; $display("FAIL lat2_data j=%0d got %h exp %h", j, rddata1, ed1);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 10'd9);
    for (int k = 0; k < 3; k++) begin
      if (k < 2) drive(1'b1, 1'b1, 4'hF, 10'd9, 32'hFFFFFFFF, 1'b1, 10'd9);
      else idle();
      total++;
      if (rdvalid0 !== 1'b0 || rdvalid1 !== 1'b0) begin
        bad++; $display("FAIL rstmid_valid k=%0d got %0b/%0b exp 0/0", k, rdvalid0, rdvalid1);
      end
      total++;
      if (rddata0 !== '0 || rddata1 !== '0) begin
        bad++; $display("FAIL rstmid_data k=%0d got %h/%h exp 0/0", k, rddata0, rddata1);
      end
    end
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 10'd9);
    idle();
    total++;
    if (rdvalid0 !== 1'b1 || rddata0 !== 32'hA5A50009) begin
      bad++; $display("FAIL rstmid_keep got %0b/%h exp 1/a5a50009", rdvalid0, rddata0);
    end
    idle();
  endtask

  task automatic test_zero_be();
    drive(1'b0, 1'b1, 4'b0000, 10'd12, 32'hFFFFFFFF, 1'b0, '0);
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 10'd12);
    idle();
    total++;
    if (rdvalid0 !== 1'b1 || rddata0 !== 32'hA5A5000C) begin
      bad++; $display("FAIL zero_be got %0b/%h exp 1/a5a5000c", rdvalid0, rddata0);
    end
    idle();
  endtask

  task automatic test_random();
    for (int k = 0; k < 403; k++) begin
      if (k < 400)
        drive(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              D'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)), D'($urandom_range(0, 15)));
      else idle();
      total++;
      if (rdvalid0 !== exp_v0 || rddata0 !== exp_d0) begin
        bad++; $display("FAIL rand0 k=%0d got %0b/%h exp %0b/%h", k, rdvalid0, rddata0, exp_v0, exp_d0);
      end
      total++;
      if (rdvalid1 !== exp_v1 || rddata1 !== exp_d1) begin
        bad++; $display("FAIL rand1 k=%0d got %0b/%h exp %0b/%h", k, rdvalid1, rddata1, exp_v1, exp_d1);
      end
    end
  endtask

  initial begin
    rst = 1'b1; wren = 1'b0; wrbe = '0; wraddr = '0; wrdata = '0; rden = 1'b0; rdaddr = '0;
    test_reset();
    test_full_write_read();
    test_byte_lanes();
    test_collision();
    test_out_reg_latency();
    test_reset_mid();
    test_zero_be();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
